// File: rtl/svm_detect_pkg.sv
// Shared constants, register map and saturation helper for the SVM
// detection stage.
package svm_detect_pkg;

    localparam logic [31:0] NEG_INF   = 32'h8000_0000;
    localparam int          X_LSB     = 24;
    localparam int          Y_LSB     = 16;
    localparam int          SCORE_LSB = 0;

    typedef enum logic [1:0] {
        SCR    = 2'd0,
        THRESH = 2'd1,
        COUNT  = 2'd2,
        RSVD   = 2'd3
    } reg_addr_e;

    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'h7FFF;
        else if (v < -32'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/svm_detect_nms.sv
// Horizontal 3-tap non-max suppression over one score row. A row-end centre
// has no right neighbour and is judged one cycle later via pend_last.
module svm_detect_nms
    import svm_detect_pkg::*;
#(
    parameter int WPI = 10
)
(
    input  logic               clk_proc,
    input  logic               reset_n,
    input  logic               acc,
    input  logic signed [31:0] data,
    input  logic [7:0]         col,
    input  logic [7:0]         row,
    input  logic signed [31:0] thresh,
    output logic               eval,
    output logic               hit,
    output logic [7:0]         x,
    output logic [7:0]         y,
    output logic signed [31:0] score
);

    logic signed [31:0] l_reg;
    logic signed [31:0] c_reg;
    logic signed [31:0] r_val;
    logic [7:0]         cx;
    logic [7:0]         cy;
    logic               pend_last;
    logic               last_col;

    assign last_col = (col == 8'(WPI - 1));

    // A col-0 arrival never judges the previous centre, so a pending row-end
    // evaluation owns the cycle; an unfinished row's tail is simply overwritten.
    always_comb begin
        eval  = 1'b0;
        r_val = NEG_INF;
        if (pend_last) begin
            eval = 1'b1;
        end else if (acc && col != 8'd0) begin
            eval  = 1'b1;
            r_val = data;
        end
        hit = eval && (c_reg > thresh) && (c_reg > l_reg) && (c_reg >= r_val);
    end

    assign x     = cx;
    assign y     = cy;
    assign score = c_reg;

    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            l_reg     <= '0;
            c_reg     <= '0;
            cx        <= '0;
            cy        <= '0;
            pend_last <= 1'b0;
        end else begin
            pend_last <= acc && last_col;
            if (acc) begin
                l_reg <= (col == 8'd0) ? NEG_INF : c_reg;
                c_reg <= data;
                cx    <= col;
                cy    <= row;
            end
        end
    end

endmodule

// File: rtl/svm_detect.sv
// SVM detection stage: thresholds window scores, applies horizontal NMS and
// streams packed detection words; frame count and status over Avalon-MM.
module svm_detect
    import svm_detect_pkg::*;
#(
    parameter int WPI           = 10,
    parameter int HPI           = 59,
    parameter int WINROWS       = 16,
    parameter int MAXDET        = 64,
    parameter int CLK_PROC_FREQ = 48
)
(
    input  logic        clk_proc,
    input  logic        reset_n,
    input  logic        in_fv,
    input  logic        in_dv,
    input  logic [31:0] in_data,
    output logic        out_fv,
    output logic        out_dv,
    output logic [31:0] out_data,
    input  logic [1:0]  addr_rel_i,
    input  logic        wr_i,
    input  logic        rd_i,
    input  logic [31:0] datawr_i,
    output logic [31:0] datard_o
);

    localparam int NROWS = HPI - WINROWS + 1;
    localparam int RW    = (NROWS > 256) ? $clog2(NROWS + 1) : 8;
    localparam int CW    = $clog2(MAXDET + 1);

    // The clock frequency is a platform annotation and drives no logic.
    if (CLK_PROC_FREQ < 1) begin : g_freq_unset
    end

    logic          fv_d, frm_act, fall_d;
    logic [1:0]    fv_pipe;
    logic          rise, fall, fv_ok, acc;
    logic [7:0]    col, col_cur;
    logic [RW-1:0] row, row_cur;
    logic          en_f;
    logic [31:0]   thr_f;
    logic          scr_en, ovf;
    logic [31:0]   thresh_r, count_r, rd_mux;
    logic [CW-1:0] det_cnt;
    logic          eval, hit, qual, emit, ovf_set;
    logic [7:0]    ex, ey;
    logic [31:0]   escore;

    always_comb begin
        rise    = in_fv & ~fv_d;
        fall    = frm_act & ~in_fv;
        fv_ok   = in_fv & (frm_act | rise);
        acc     = in_dv & fv_ok;
        col_cur = rise ? '0 : col;
        row_cur = rise ? '0 : row;
        qual    = eval & hit & en_f;
        emit    = qual & (det_cnt < CW'(MAXDET));
        ovf_set = qual & ~emit;
    end

    svm_detect_nms #(.WPI(WPI)) u_nms (
        .clk_proc (clk_proc),
        .reset_n  (reset_n),
        .acc      (acc),
        .data     (in_data),
        .col      (col_cur),
        .row      (row_cur[7:0]),
        .thresh   (thr_f),
        .eval     (eval),
        .hit      (hit),
        .x        (ex),
        .y        (ey),
        .score    (escore)
    );

    // fv_d resets high so a frame already in flight at reset release is
    // ignored until in_fv has been seen low.
    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            fv_d    <= 1'b1;
            frm_act <= 1'b0;
            fall_d  <= 1'b0;
            fv_pipe <= '0;
            en_f    <= 1'b0;
            thr_f   <= '0;
        end else begin
            fv_d    <= in_fv;
            fall_d  <= fall;
            fv_pipe <= {fv_pipe[0], fv_ok};
            if (rise) begin
                frm_act <= 1'b1;
                en_f    <= scr_en;
                thr_f   <= thresh_r;
            end else if (!in_fv) begin
                frm_act <= 1'b0;
            end
        end
    end

    assign out_fv = fv_pipe[1];

    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            col     <= '0;
            row     <= '0;
            det_cnt <= '0;
            count_r <= '0;
        end else begin
            if (acc) begin
                if (col_cur == 8'(WPI - 1)) begin
                    col <= '0;
                    row <= row_cur + RW'(1);
                end else begin
                    col <= col_cur + 8'd1;
                    row <= row_cur;
                end
            end else if (rise) begin
                col <= '0;
                row <= '0;
            end
            if (rise)
                det_cnt <= '0;
            else if (emit)
                det_cnt <= det_cnt + CW'(1);
            // fall_d lands after any row-end flush has been counted
            if (fall_d)
                count_r <= 32'(det_cnt);
        end
    end

    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            out_dv   <= 1'b0;
            out_data <= '0;
        end else begin
            out_dv <= emit;
            if (emit)
                out_data <= (32'(ex) << X_LSB) | (32'(ey) << Y_LSB)
                          | (32'(sat16(escore)) << SCORE_LSB);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr_e'(addr_rel_i))
            SCR:     rd_mux = {30'd0, ovf, scr_en};
            THRESH:  rd_mux = thresh_r;
            COUNT:   rd_mux = count_r;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            scr_en   <= 1'b0;
            ovf      <= 1'b0;
            thresh_r <= '0;
            datard_o <= '0;
        end else begin
            if (wr_i) begin
                case (reg_addr_e'(addr_rel_i))
                    SCR:     scr_en   <= datawr_i[0];
                    THRESH:  thresh_r <= datawr_i;
                    default: ;
                endcase
            end
            if (ovf_set)
                ovf <= 1'b1;
            else if (wr_i && reg_addr_e'(addr_rel_i) == SCR && datawr_i[1])
                ovf <= 1'b0;
            if (rd_i)
                datard_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_svm_detect.sv
// Directed bench for svm_detect: table of frames with hand-computed
// detections plus sequences for mid-frame writes, overflow clear and reset.
module tb_svm_detect;

    localparam int WPI    = 10;
    localparam int MAXDET = 4;

    logic        clk_proc = 1'b0;
    logic        reset_n  = 1'b0;
    logic        in_fv = 1'b0, in_dv = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_fv, out_dv;
    logic [31:0] out_data;
    logic [1:0]  addr_rel_i = '0;
    logic        wr_i = 1'b0, rd_i = 1'b0;
    logic [31:0] datawr_i = '0;
    logic [31:0] datard_o;

    svm_detect #(.WPI(WPI), .HPI(59), .WINROWS(16), .MAXDET(MAXDET), .CLK_PROC_FREQ(48)) dut (
        .clk_proc(clk_proc), .reset_n(reset_n), .in_fv(in_fv), .in_dv(in_dv), .in_data(in_data),
        .out_fv(out_fv), .out_dv(out_dv), .out_data(out_data), .addr_rel_i(addr_rel_i),
        .wr_i(wr_i), .rd_i(rd_i), .datawr_i(datawr_i), .datard_o(datard_o)
    );

    always #5 clk_proc = ~clk_proc;

    int cyc = 0;
    always @(posedge clk_proc) cyc <= cyc + 1;

    logic [31:0] det_q[$];
    int          dcyc_q[$];
    logic        fv_q[$];
    always @(negedge clk_proc) begin
        if (out_dv) begin
            det_q.push_back(out_data);
            dcyc_q.push_back(cyc);
            fv_q.push_back(out_fv);
        end
    end

    typedef struct packed {
        logic             en;
        logic [31:0]      thresh;
        logic [31:0]      base;
        logic [2:0]       nrows;
        logic [2:0]       npk;
        logic [5:0][7:0]  pk_x;
        logic [5:0][7:0]  pk_y;
        logic [5:0][31:0] pk_v;
        logic [2:0]       ndet;
        logic [5:0][31:0] det;
        logic [31:0]      cnt;
        logic             ovf;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_proc);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        addr_rel_i = a; datawr_i = d; wr_i = 1'b1;
        tick();
        wr_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
        addr_rel_i = a; rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
        d = datard_o;
    endtask

    function automatic vec_t mkvec(logic en, logic [31:0] th, logic [31:0] base, int nrows, int cnt, logic ovf);
        vec_t v = '0;
        v.en = en; v.thresh = th; v.base = base; v.nrows = 3'(nrows); v.cnt = 32'(cnt); v.ovf = ovf;
        return v;
    endfunction

    function automatic vec_t add_pk(vec_t v, int x, int y, logic [31:0] val);
        v.pk_x[v.npk] = 8'(x); v.pk_y[v.npk] = 8'(y); v.pk_v[v.npk] = val;
        v.npk = v.npk + 3'd1;
        return v;
    endfunction

    function automatic vec_t add_det(vec_t v, logic [31:0] w);
        v.det[v.ndet] = w;
        v.ndet = v.ndet + 3'd1;
        return v;
    endfunction

    function automatic logic [31:0] sample(vec_t v, int k);
        logic [31:0] s = v.base;
        for (int p = 0; p < 6; p++)
            if (p < int'(v.npk) && int'(v.pk_x[p]) == k % WPI && int'(v.pk_y[p]) == k / WPI)
                s = v.pk_v[p];
        return s;
    endfunction

    // First sample is driven while cyc == c0; it is accepted at the next edge.
    task automatic send_frame(input vec_t v, output int c0);
        in_fv = 1'b1;
        tick(); tick();
        c0 = cyc;
        for (int k = 0; k < int'(v.nrows) * WPI; k++) begin
            in_dv = 1'b1; in_data = sample(v, k);
            tick();
        end
        in_dv = 1'b0;
        tick(); tick();
        in_fv = 1'b0;
        repeat (6) tick();
    endtask

    task automatic clr_q();
        det_q.delete(); dcyc_q.delete(); fv_q.delete();
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int c0, x, y, n;
        logic [31:0] rd, w;
        reg_wr(2'd1, v.thresh);
        reg_wr(2'd0, {31'd0, v.en});
        clr_q();
        send_frame(v, c0);
        n = det_q.size();
        chk($sformatf("v%0d ndet", id), 32'(n), 32'(v.ndet));
        for (int i = 0; i < int'(v.ndet) && i < n; i++) begin
            w = v.det[i];
            x = int'(w[31:24]);
            y = int'(w[23:16]);
            chk($sformatf("v%0d det%0d data", id, i), det_q[i], w);
            chk($sformatf("v%0d det%0d cycle", id, i), 32'(dcyc_q[i]), 32'(c0 + y * WPI + x + 2));
            chk($sformatf("v%0d det%0d in_fv", id, i), 32'(fv_q[i]), 32'd1);
        end
        reg_rd(2'd2, rd);
        chk($sformatf("v%0d count", id), rd, v.cnt);
        reg_rd(2'd0, rd);
        chk($sformatf("v%0d ovf", id), {31'd0, rd[1]}, {31'd0, v.ovf});
        chk($sformatf("v%0d fv_low", id), {31'd0, out_fv}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int c0, n;
        logic [31:0] rd;

        v = mkvec(1'b1, 32'd0, 32'd0, 1, 1, 1'b0);
        v = add_pk(v, 0, 0, 32'd1); v = add_pk(v, 1, 0, 32'd5); v = add_pk(v, 2, 0, 32'd3);
        vecs[0] = add_det(v, 32'h0100_0005);
        v = mkvec(1'b1, 32'd0, 32'hFFFF_FFF6, 4, 1, 1'b0);
        v = add_pk(v, 9, 2, 32'd7);
        vecs[1] = add_det(v, 32'h0902_0007);
        v = mkvec(1'b1, 32'd0, 32'd0, 1, 1, 1'b0);
        v = add_pk(v, 3, 0, 32'd4); v = add_pk(v, 4, 0, 32'd4); v = add_pk(v, 5, 0, 32'd4);
        vecs[2] = add_det(v, 32'h0300_0004);
        v = mkvec(1'b1, 32'd0, 32'd0, 1, 1, 1'b0);
        v = add_pk(v, 2, 0, 32'h0010_0000);
        vecs[3] = add_det(v, 32'h0200_7FFF);
        v = mkvec(1'b1, 32'h8000_0001, 32'h8000_0001, 1, 1, 1'b0);
        v = add_pk(v, 4, 0, 32'hFFF0_0000);
        vecs[4] = add_det(v, 32'h0400_8000);
        v = mkvec(1'b0, 32'd0, 32'd0, 1, 0, 1'b0);
        vecs[5] = add_pk(v, 1, 0, 32'd5);
        v = mkvec(1'b1, 32'd0, 32'd0, 2, 2, 1'b0);
        v = add_pk(v, 9, 0, 32'd3); v = add_pk(v, 0, 1, 32'd9);
        v = add_det(v, 32'h0900_0003);
        vecs[6] = add_det(v, 32'h0001_0009);
        v = mkvec(1'b1, 32'd0, 32'd0, 2, 4, 1'b1);
        v = add_pk(v, 1, 0, 32'd10); v = add_pk(v, 4, 0, 32'd20); v = add_pk(v, 7, 0, 32'd30);
        v = add_pk(v, 2, 1, 32'd40); v = add_pk(v, 5, 1, 32'd50); v = add_pk(v, 9, 1, 32'd60);
        v = add_det(v, 32'h0100_000A); v = add_det(v, 32'h0400_0014);
        v = add_det(v, 32'h0700_001E);
        vecs[7] = add_det(v, 32'h0201_0028);

        repeat (3) tick();
        chk("rst out_fv", {31'd0, out_fv}, 32'd0);
        chk("rst out_dv", {31'd0, out_dv}, 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst datard", datard_o, 32'd0);
        reset_n = 1'b1;
        tick();
        reg_rd(2'd0, rd); chk("rst scr", rd, 32'd0);
        reg_rd(2'd1, rd); chk("rst thresh", rd, 32'd0);
        reg_rd(2'd2, rd); chk("rst count", rd, 32'd0);
        reg_wr(2'd1, 32'h0000_1234);
        reg_rd(2'd3, rd); chk("addr3", rd, 32'd0);
        reg_rd(2'd1, rd); chk("thresh rw", rd, 32'h0000_1234);
        tick();
        chk("datard hold", datard_o, 32'h0000_1234);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        reg_wr(2'd0, 32'd3);
        reg_rd(2'd0, rd); chk("ovf clear", rd, 32'd1);

        // threshold raised mid-frame applies from the next frame only
        reg_wr(2'd1, 32'd0);
        clr_q();
        fork
            send_frame(vecs[0], c0);
            begin repeat (6) tick(); reg_wr(2'd1, 32'd100); end
        join
        n = det_q.size();
        chk("midwr ndet", 32'(n), 32'd1);
        if (n > 0) chk("midwr det", det_q[0], 32'h0100_0005);
        reg_rd(2'd1, rd); chk("midwr thresh", rd, 32'd100);
        clr_q();
        send_frame(vecs[0], c0);
        chk("next frame ndet", 32'(det_q.size()), 32'd0);
        reg_rd(2'd2, rd); chk("next frame count", rd, 32'd0);

        // reset in the middle of a frame
        in_fv = 1'b1;
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            in_dv = 1'b1; in_data = (k == 1) ? 32'd500 : 32'd0;
            tick();
        end
        #2 reset_n = 1'b0;
        #1;
        chk("midrst out_fv", {31'd0, out_fv}, 32'd0);
        chk("midrst out_dv", {31'd0, out_dv}, 32'd0);
        chk("midrst out_data", out_data, 32'd0);
        chk("midrst datard", datard_o, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        clr_q();
        n = 0;
        for (int k = 0; k < 12; k++) begin
            in_dv = 1'b1; in_data = (k % 3 == 1) ? 32'd900 : 32'd0;
            tick();
            if (out_fv) n++;
        end
        in_dv = 1'b0;
        chk("postrst out_fv cycles", 32'(n), 32'd0);
        chk("postrst ndet", 32'(det_q.size()), 32'd0);
        reg_rd(2'd0, rd); chk("postrst scr", rd, 32'd0);
        reg_rd(2'd1, rd); chk("postrst thresh", rd, 32'd0);
        reg_rd(2'd2, rd); chk("postrst count", rd, 32'd0);
        in_fv = 1'b0;
        tick(); tick();
        run_vec(8, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/svm_detect.md
Name: svm_detect

Overview:
- Downstream stage of the sliding-window SVM scorer.
- Consumes one signed 32-bit window score per in_dv, raster order: WPI scores per row, HPI-WINROWS+1 rows per frame.
- Thresholds each score, applies 1-D horizontal non-max suppression, and emits one packed detection word per surviving window on a GPStudio flow.
- Per-frame detection count and status are readable over Avalon-MM.

Parameters:
WPI, 10, windows per score row (max 256)
HPI, 59, image height in cells; score rows per frame = HPI-WINROWS+1
WINROWS, 16, window height in cells
MAXDET, 64, max detections emitted per frame
CLK_PROC_FREQ, 48, GPStudio clock annotation (MHz, unused in logic)

Ports:
clk_proc  in  1  clock
reset_n  in  1  reset
in_fv  in  1  input frame valid
in_dv  in  1  input score valid
in_data  in  32  signed SVM score
out_fv  out  1  output frame valid
out_dv  out  1  detection valid
out_data  out  32  {x[7:0], y[7:0], score_sat[15:0]}
addr_rel_i  in  2  Avalon-MM register address
wr_i  in  1  Avalon-MM write strobe
rd_i  in  1  Avalon-MM read strobe
datawr_i  in  32  Avalon-MM write data
datard_o  out  32  Avalon-MM read data, registered

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk_proc.
  - All registers clear on reset: out_fv=0, out_dv=0, out_data=0, datard_o=0.
  - SCR=0 (block disabled), THRESH=0, COUNT=0.
  - Reset mid-frame discards all state. Output resumes at the next in_fv rising edge.
- Registers:
  - addr 0 SCR (R/W): bit0 enable, bit1 overflow (sticky, RO; cleared by writing SCR with bit1=1).
  - addr 1 THRESH (R/W): signed 32-bit threshold.
  - addr 2 COUNT (RO): detections emitted in the last completed frame.
  - addr 3 reads 0.
  - Read data is registered: datard_o updates the cycle after rd_i and holds otherwise.
- Frame start (in_fv 0->1):
  - Latch enable and THRESH into frame copies. Mid-frame register writes affect the next frame only.
  - Clear col, row and det_cnt.
- Counters:
  - col increments on each in_dv and wraps from WPI-1 to 0; row increments on that wrap.
  - in_dv while in_fv=0 is ignored.
- NMS window: registers left (L), centre (C), with a pending flag. col 0 has L=-inf (0x80000000 treated as strictly minimal).
- Evaluation of centre C at (x,y):
  - Condition: C > THRESH, C > L, and C >= R. All comparisons are signed 32-bit.
  - For x<WPI-1: R is the next score in the row, and evaluation happens in the cycle that score is accepted.
  - For x=WPI-1: R=-inf. Evaluation happens one cycle after acceptance via a pending_last flag.
  - A col-0 sample arriving in the same cycle as pending_last produces no evaluation of its own, so at most one evaluation occurs per cycle.
- Emission:
  - If the condition holds, enable=1 and det_cnt<MAXDET, then out_dv=1 on the cycle after evaluation.
  - out_data = {x, y, sat16(C)}, where sat16 clamps to [-32768, 32767].
  - x and y are the low 8 bits of the counters.
  - out_dv is a single-cycle pulse; out_data holds its last value otherwise.
- Overflow: a qualifying detection when det_cnt==MAXDET is dropped and sets overflow.
- Frame end (in_fv 1->0):
  - Flush pending_last normally.
  - COUNT <= det_cnt after the flush, 2 cycles after the falling edge.
  - Partial last row: columns received are evaluated; an unfinished row's last received sample gets no R and is dropped.
- out_fv = in_fv delayed by 2 cycles, so every out_dv lies inside out_fv.

Decomposition:
- Shared package svm_detect_pkg:
  - Constants NEG_INF=32'h80000000, field offsets X_LSB=24, Y_LSB=16, SCORE_LSB=0.
  - Register addresses SCR=0, THRESH=1, COUNT=2.
- One natural sub-module, svm_detect_nms: 3-tap compare and pending_last logic, emitting eval/hit/x/y/score.
- Top level holds counters, frame edges, Avalon registers and the output register.

Test Plan:
1. Enable=1, THRESH=0, row scores [1,5,3,0,...,0] on row 0 -> exactly one out_dv, out_data=0x01_00_0005, COUNT=1 after frame.
2. Last column peak: row 2 scores all -10 except col 9=7 -> out_dv 2 cycles after col-9 acceptance, out_data=0x09_02_0007; back-to-back col 0 of row 3 causes no collision.
3. Plateau [4,4,4] at cols 3-5, THRESH=0 -> only x=3 detected (C>L fails at 4, C>=R holds at 3).
4. Score 0x00100000 above threshold -> score field 0x7FFF; score -0x00100000 with THRESH=-0x7FFFFFFF -> 0x8000.
5. MAXDET=4, frame with 6 isolated peaks -> 4 out_dv pulses, COUNT=4, SCR bit1=1; write SCR=0x3 clears the overflow bit.
6. THRESH written mid-frame from 0 to 100 -> current frame still uses 0; reset_n pulse mid-frame -> out_fv/out_dv low, registers zero, next frame processed correctly.
